// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//
// Holds the data-width macro, the request size encodings, the FSM state
// encodings and a small alignment helper used by the optional misalignment
// trap (enabled by defining LSU_MISALIGN_TRAP_EN when building the top).

`ifndef LSU_DATA_W
`define LSU_DATA_W 64
`endif

package load_store_unit_pkg;

    localparam int DATA_W = `LSU_DATA_W;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsuSize_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_WAIT  = 3'd1,
        RMW_WAIT = 3'd2,
        RMW_WR   = 3'd3,
        ST_WR    = 3'd4,
        RESP     = 3'd5
    } lsuState_t;

    // A half access must sit on an even address, a word access on a
    // multiple of four; bytes are always aligned.
    function automatic logic isMisaligned(input lsuSize_t size, input logic [1:0] addrLow);
        logic result;
        result = 1'b0;
        case (size)
            SIZE_HALF: result = addrLow[0];
            SIZE_WORD: result = (addrLow != 2'b00);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//
// Ports:
//   size       - access size of the captured request
//   isUnsigned - zero-extend loads when 1, sign-extend when 0
//   memWord    - 32-bit little-endian word returned by memory
//   storeData  - low 16 bits of the store data
//   loadData   - extracted and extended load result
//   mergedWord - memWord with its low 1 or 2 bytes replaced by storeData

module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsuSize_t          size,
    input  logic              isUnsigned,
    input  logic [31:0]       memWord,
    input  logic [15:0]       storeData,
    output logic [DATA_W-1:0] loadData,
    output logic [31:0]       mergedWord
);

    // Load extraction always starts at byte lane 0 because the memory port
    // returns the word starting exactly at the request address.
    always_comb begin
        loadData   = '0;
        mergedWord = memWord;
        case (size)
            SIZE_BYTE: begin
                loadData   = {{(DATA_W-8){~isUnsigned & memWord[7]}}, memWord[7:0]};
                mergedWord = {memWord[31:8], storeData[7:0]};
            end
            SIZE_HALF: begin
                loadData   = {{(DATA_W-16){~isUnsigned & memWord[15]}}, memWord[15:0]};
                mergedWord = {memWord[31:16], storeData};
            end
            SIZE_WORD: begin
                loadData   = {{(DATA_W-32){~isUnsigned & memWord[31]}}, memWord};
            end
            default: begin
                loadData   = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a single-request CPU interface to a 4-byte
// little-endian memory word port.
//
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   req_valid / req_ready   - request handshake, ready only in IDLE
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata               - request fields
//   resp_valid, resp_rdata,
//   resp_fault              - one-cycle completion pulse and its payload
//   mem_read_en, mem_write_en,
//   mem_addr, mem_wdata     - registered memory commands
//   mem_rdata               - memory read data, valid while mem_read_en is high
//
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses instead of issuing them at the unaligned address.

module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsuState_t         state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_fault_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_read_en_q;
    logic              mem_write_en_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    lsuSize_t          size_q;
    logic              unsigned_q;
    logic [15:0]       wdata_q;

    lsuSize_t          reqSize;
    logic              misalignFault;
    logic              reqFault;
    logic [DATA_W-1:0] loadData;
    logic [31:0]       mergedWord;
    logic              unusedBits;

    assign reqSize = lsuSize_t'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalignFault = isMisaligned(reqSize, req_addr[1:0]);
`else
    assign misalignFault = 1'b0;
`endif

    assign reqFault = (reqSize == SIZE_ILLEGAL) || misalignFault;

    // Only the low word of memory data and the low word of store data are
    // ever meaningful on a 4-byte port.
    assign unusedBits = &{1'b0, req_wdata[DATA_W-1:32], mem_rdata[DATA_W-1:32]};

    lsu_align u_align (
        .size       (size_q),
        .isUnsigned (unsigned_q),
        .memWord    (mem_rdata[31:0]),
        .storeData  (wdata_q),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    // Request sequencer. Every output is a register; the command pulses
    // default low each cycle so each enable lasts exactly one cycle, and an
    // async reset drops them immediately so an aborted RMW never writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_rdata_q   <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            size_q         <= SIZE_BYTE;
            unsigned_q     <= 1'b0;
            wdata_q        <= '0;
        end else begin
            resp_valid_q   <= 1'b0;
            resp_fault_q   <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ready_q && req_valid) begin
                        req_ready_q <= 1'b0;
                        size_q      <= reqSize;
                        unsigned_q  <= req_unsigned;
                        wdata_q     <= req_wdata[15:0];
                        if (reqFault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_write && (reqSize == SIZE_WORD)) begin
                            state_q        <= ST_WR;
                            mem_write_en_q <= 1'b1;
                            mem_addr_q     <= req_addr;
                            mem_wdata_q    <= {{(DATA_W-32){1'b0}}, req_wdata[31:0]};
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q       <= req_write ? RMW_WAIT : LD_WAIT;
                            mem_read_en_q <= 1'b1;
                            mem_addr_q    <= req_addr;
                        end
                    end else begin
                        // Covers the first cycle after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                LD_WAIT: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= loadData;
                end
                RMW_WAIT: begin
                    state_q        <= RMW_WR;
                    mem_write_en_q <= 1'b1;
                    mem_wdata_q    <= {{(DATA_W-32){1'b0}}, mergedWord};
                end
                RMW_WR, ST_WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_fault   = resp_fault_q;
    assign resp_rdata   = resp_rdata_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
//
// A byte-array memory sits on the memory port and returns data while
// mem_read_en is high. Each accepted request pushes its expected response
// (data, fault, latency, read/write counts, address) onto a scoreboard queue
// computed from a separate reference byte array; a negedge monitor pops and
// compares when resp_valid is seen.

module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [7:0]  mem    [0:255] = '{default: 8'h00};
    logic [7:0]  refMem [0:255] = '{default: 8'h00};
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = '0;
    logic [7:0]  pokeData = '0;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;
    int readCount = 0;
    int writeCount = 0;
    int overlapCount = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          latency;
        int          reads;
        int          writes;
        int          readBase;
        int          writeBase;
        int          acceptCycle;
        logic [63:0] addr;
    } expEntry_t;

    expEntry_t scoreQ[$];

    load_store_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount++;

    // Memory model: 256-byte space, little-endian, word returned only while
    // a read is being issued, four-byte writes at the rising edge.
    assign mem_rdata = mem_read_en ?
        {32'h0, mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
         mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]} : 64'h0;

    always @(posedge clock) begin
        if (pokeEn) mem[pokeAddr] <= pokeData;
        if (mem_write_en) begin
            for (int k = 0; k < 4; k++)
                mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[8*k +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic modelFault(input logic [1:0] sz, input logic [63:0] a);
        logic f;
        f = (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        f = f || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
        return f;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [1:0] sz, input logic uns, input logic [63:0] a);
        logic [31:0] w;
        logic [63:0] r;
        w = {refMem[a[7:0] + 8'd3], refMem[a[7:0] + 8'd2], refMem[a[7:0] + 8'd1], refMem[a[7:0]]};
        case (sz)
            2'b00:   r = uns ? {56'h0, w[7:0]}  : {{56{w[7]}}, w[7:0]};
            2'b01:   r = uns ? {48'h0, w[15:0]} : {{48{w[15]}}, w[15:0]};
            2'b10:   r = uns ? {32'h0, w}       : {{32{w[31]}}, w};
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    task automatic modelStore(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) refMem[a[7:0] + 8'(k)] = wd[8*k +: 8];
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        pokeEn = 1'b1;
        pokeAddr = a;
        pokeData = d;
        refMem[a] = d;
        @(negedge clock);
        pokeEn = 1'b0;
    endtask

    // Presents one request and holds it until accepted; req_valid stays high
    // afterwards so consecutive calls form a back-to-back stream.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [63:0] a, input logic [63:0] wd, input logic expectResp);
        expEntry_t e;
        int waitCycles;
        @(negedge clock);
        req_write = wr;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        waitCycles = 0;
        while (!req_ready && waitCycles < 50) begin
            @(negedge clock);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("acceptTimeout", 64'(req_ready), 64'h1);
            req_valid = 1'b0;
            return;
        end
        if (expectResp) begin
            e.fault = modelFault(sz, a);
            e.addr = a;
            e.readBase = readCount;
            e.writeBase = writeCount;
            e.acceptCycle = cycleCount + 1;
            if (e.fault) begin
                e.rdata = 64'h0; e.latency = 1; e.reads = 0; e.writes = 0;
            end else if (!wr) begin
                e.rdata = modelLoad(sz, uns, a); e.latency = 2; e.reads = 1; e.writes = 0;
            end else if (sz == 2'b10) begin
                e.rdata = 64'h0; e.latency = 2; e.reads = 0; e.writes = 1;
                modelStore(sz, a, wd);
            end else begin
                e.rdata = 64'h0; e.latency = 3; e.reads = 1; e.writes = 1;
                modelStore(sz, a, wd);
            end
            scoreQ.push_back(e);
        end
        @(posedge clock);
    endtask

    task automatic dropValid();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (scoreQ.size() != 0 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        if (scoreQ.size() != 0) checkOutput("drainTimeout", 64'(scoreQ.size()), 64'h0);
        repeat (2) @(negedge clock);
    endtask

    // Response monitor. Latency counts rising edges from the accept edge to
    // the edge at which resp_valid is first sampled high.
    always @(negedge clock) begin
        expEntry_t e;
        if (mem_read_en && mem_write_en) overlapCount++;
        if (mem_read_en) readCount++;
        if (mem_write_en) writeCount++;
        if ((mem_read_en || mem_write_en) && scoreQ.size() != 0)
            checkOutput("memAddr", mem_addr, scoreQ[0].addr);
        if (resp_valid) begin
            if (scoreQ.size() == 0) begin
                checkOutput("spuriousResp", 64'(resp_valid), 64'h0);
            end else begin
                e = scoreQ.pop_front();
                checkOutput("respRdata", resp_rdata, e.rdata);
                checkOutput("respFault", 64'(resp_fault), 64'(e.fault));
                checkOutput("latency", 64'(cycleCount + 1 - e.acceptCycle), 64'(e.latency));
                checkOutput("readPulses", 64'(readCount - e.readBase), 64'(e.reads));
                checkOutput("writePulses", 64'(writeCount - e.writeBase), 64'(e.writes));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checkCount, errorCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  randLow;
        logic [63:0] randAddr;

        // Preload while reset is held.
        preload(8'h10, 8'h80);
        preload(8'h11, 8'h01);
        preload(8'h12, 8'h02);
        preload(8'h13, 8'h03);
        preload(8'h14, 8'h44);
        preload(8'h15, 8'h55);

        @(negedge clock);
        checkOutput("rstReady", 64'(req_ready), 64'h0);
        checkOutput("rstRespValid", 64'(resp_valid), 64'h0);
        checkOutput("rstRespFault", 64'(resp_fault), 64'h0);
        checkOutput("rstReadEn", 64'(mem_read_en), 64'h0);
        checkOutput("rstWriteEn", 64'(mem_write_en), 64'h0);
        checkOutput("rstRdata", resp_rdata, 64'h0);
        checkOutput("rstMemAddr", mem_addr, 64'h0);
        checkOutput("rstMemWdata", mem_wdata, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("readyAfterReset", 64'(req_ready), 64'h1);

        // Directed loads from the preloaded word 80 01 02 03.
        applyStimulus(1'b0, 2'b00, 1'b0, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b1, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 64'h12, 64'h0, 1'b1);
        dropValid();
        waitDrain();

        // Byte store via read-modify-write.
        applyStimulus(1'b1, 2'b00, 1'b0, 64'h11, 64'h0000_0000_0000_00AA, 1'b1);
        dropValid();
        waitDrain();
        checkOutput("sbByte10", 64'(mem[8'h10]), 64'h80);
        checkOutput("sbByte11", 64'(mem[8'h11]), 64'hAA);
        checkOutput("sbByte12", 64'(mem[8'h12]), 64'h02);
        checkOutput("sbByte13", 64'(mem[8'h13]), 64'h03);

        // Word store, half store on top of it, then readback.
        applyStimulus(1'b1, 2'b10, 1'b0, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 64'h22, 64'hFFFF_FFFF_FFFF_1234, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 1'b1);
        dropValid();
        waitDrain();
        checkOutput("swUpperClear", 64'(mem[8'h24]), 64'h00);

        // Illegal size and an unaligned word load.
        applyStimulus(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b0, 64'h10, 64'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 64'h12, 64'h0, 1'b1);
        dropValid();
        waitDrain();

        // Reset pulse while the RMW read is outstanding.
        applyStimulus(1'b1, 2'b00, 1'b0, 64'h11, 64'h0000_0000_0000_0055, 1'b0);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("readyAfterAbort", 64'(req_ready), 64'h1);
        repeat (3) @(negedge clock);
        for (int k = 16; k < 20; k++)
            checkOutput("abortMemUnchanged", 64'(mem[k]), 64'(refMem[k]));

        // Random back-to-back stream, including upper address bits.
        for (int i = 0; i < 24; i++) begin
            randLow = 8'($urandom_range(8'h40, 8'h7F));
            randAddr = {32'($urandom), 24'($urandom), randLow};
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          randAddr, {32'($urandom), 32'($urandom)}, 1'b1);
        end
        dropValid();
        waitDrain();

        for (int k = 0; k < 256; k++)
            checkOutput("finalMem", 64'(mem[k]), 64'(refMem[k]));
        checkOutput("noReadWriteOverlap", 64'(overlapCount), 64'h0);
        checkOutput("scoreboardEmpty", 64'(scoreQ.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
